// File: rtl/spi_master_arbiter_if.sv
// Register-side bus between the arbiter and the shared spi_master instance.
// The master modport is the arbiter's view; the slave modport is the spi_master's view.
interface spi_master_arbiter_if #(
  parameter int DATA_SIZE = 16
);
  logic                 o_spi_csn;
  logic [DATA_SIZE-1:0] o_spi_data;
  logic                 o_spi_wr;
  logic                 o_spi_rd;
  logic                 o_spi_start;
  logic [1:0]           o_spi_addr;
  logic                 o_spi_cpol;
  logic                 o_spi_cpha;
  logic                 o_spi_lsb_first;
  logic [DATA_SIZE-1:0] i_spi_data;
  logic                 i_spi_tx_ready;
  logic                 i_spi_rx_ready;
  logic                 i_spi_tx_error;
  logic                 i_spi_rx_error;

  modport master (
    output o_spi_csn, o_spi_data, o_spi_wr, o_spi_rd, o_spi_start,
           o_spi_addr, o_spi_cpol, o_spi_cpha, o_spi_lsb_first,
    input  i_spi_data, i_spi_tx_ready, i_spi_rx_ready,
           i_spi_tx_error, i_spi_rx_error
  );

  modport slave (
    input  o_spi_csn, o_spi_data, o_spi_wr, o_spi_rd, o_spi_start,
           o_spi_addr, o_spi_cpol, o_spi_cpha, o_spi_lsb_first,
    output i_spi_data, i_spi_tx_ready, i_spi_rx_ready,
           i_spi_tx_error, i_spi_rx_error
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin scheduler sharing one spi_master between NUM_REQ requesters:
// one full-duplex word per grant, with RX timeout and master error reporting.
module spi_master_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 16,
  parameter int TIMEOUT   = 4095
) (
  input  logic                         i_sys_clk,
  input  logic                         i_sys_rst,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*DATA_SIZE-1:0] i_req_data,
  input  logic [NUM_REQ*2-1:0]         i_req_addr,
  input  logic [NUM_REQ*3-1:0]         i_req_mode,
  output logic [NUM_REQ-1:0]           o_req_ack,
  output logic [NUM_REQ-1:0]           o_rsp_valid,
  output logic [DATA_SIZE-1:0]         o_rsp_data,
  output logic                         o_rsp_err,
  output logic                         o_busy,
  spi_master_arbiter_if.master         spi
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]      TO_LAST = CW'(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE_HOT = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_RX,
    S_READ,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t               r_state;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_gnt;
  logic [CW-1:0]        r_cnt;
  logic                 r_err;

  logic [NUM_REQ-1:0]   r_ack;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [DATA_SIZE-1:0] r_rsp_data;
  logic                 r_rsp_err;
  logic                 r_busy;
  logic                 r_csn;
  logic [DATA_SIZE-1:0] r_spi_data;
  logic                 r_wr;
  logic                 r_rd;
  logic                 r_start;
  logic [1:0]           r_addr;
  logic                 r_cpol;
  logic                 r_cpha;
  logic                 r_lsb;

  logic                 w_any;
  logic [PW-1:0]        w_gnt;
  logic [DATA_SIZE-1:0] w_data;
  logic [1:0]           w_addr;
  logic [2:0]           w_mode;
  logic                 w_spi_err;
  int                   w_dist;
  int                   w_best;

  assign w_any     = |i_req;
  assign w_spi_err = spi.i_spi_tx_error | spi.i_spi_rx_error;

  // Winner is the asserted requester with the smallest upward distance
  // from the last grant (distance 0 is the slot just after the pointer).
  always_comb begin
    w_gnt  = '0;
    w_data = '0;
    w_addr = '0;
    w_mode = '0;
    w_dist = 0;
    w_best = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = j - int'(r_ptr) - 1;
      if (w_dist < 0) begin
        w_dist = w_dist + NUM_REQ;
      end
      if (i_req[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_gnt  = PW'(j);
        w_data = i_req_data[j*DATA_SIZE +: DATA_SIZE];
        w_addr = i_req_addr[j*2 +: 2];
        w_mode = i_req_mode[j*3 +: 3];
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= PW'(NUM_REQ - 1);
      r_gnt       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_ack       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_csn       <= 1'b1;
      r_spi_data  <= '0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_start     <= 1'b0;
      r_addr      <= '0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_lsb       <= 1'b0;
    end else begin
      r_ack       <= '0;
      r_rsp_valid <= '0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_start     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_rsp_err <= 1'b0;
          if (w_any && spi.i_spi_tx_ready) begin
            r_state    <= S_LOAD;
            r_ptr      <= w_gnt;
            r_gnt      <= w_gnt;
            r_ack      <= ONE_HOT << w_gnt;
            r_spi_data <= w_data;
            r_addr     <= w_addr;
            {r_cpol, r_cpha, r_lsb} <= w_mode;
            r_csn      <= 1'b0;
            r_wr       <= 1'b1;
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
            r_cnt      <= '0;
          end
        end
        S_LOAD: begin
          r_err   <= r_err | w_spi_err;
          r_start <= 1'b1;
          r_state <= S_START;
        end
        S_START: begin
          r_err   <= r_err | w_spi_err;
          r_cnt   <= '0;
          r_state <= S_WAIT_RX;
        end
        S_WAIT_RX: begin
          r_err <= r_err | w_spi_err;
          // rx_ready wins over a timeout landing in the same cycle
          if (spi.i_spi_rx_ready) begin
            r_rd    <= 1'b1;
            r_state <= S_READ;
          end else if (r_cnt == TO_LAST) begin
            r_rsp_valid <= ONE_HOT << r_gnt;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_csn       <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_READ: begin
          r_err   <= r_err | w_spi_err;
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_rsp_data  <= spi.i_spi_data;
          r_rsp_valid <= ONE_HOT << r_gnt;
          r_rsp_err   <= r_err | w_spi_err;
          r_csn       <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          r_rsp_err <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_csn   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ack           = r_ack;
  assign o_rsp_valid         = r_rsp_valid;
  assign o_rsp_data          = r_rsp_data;
  assign o_rsp_err           = r_rsp_err;
  assign o_busy              = r_busy;
  assign spi.o_spi_csn       = r_csn;
  assign spi.o_spi_data      = r_spi_data;
  assign spi.o_spi_wr        = r_wr;
  assign spi.o_spi_rd        = r_rd;
  assign spi.o_spi_start     = r_start;
  assign spi.o_spi_addr      = r_addr;
  assign spi.o_spi_cpol      = r_cpol;
  assign spi.o_spi_cpha      = r_cpha;
  assign spi.o_spi_lsb_first = r_lsb;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter with a behavioural spi_master model.
module tb_spi_master_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int TO = 40;

  typedef struct {
    int          idx;
    logic [15:0] tx;
    logic [1:0]  addr;
    logic [2:0]  mode;
    int          delay;
    logic [15:0] rx;
    bit          err_pulse;
    bit          no_rx;
  } xfer_t;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    i_req;
  logic [NR*DW-1:0] i_req_data;
  logic [NR*2-1:0]  i_req_addr;
  logic [NR*3-1:0]  i_req_mode;
  logic [NR-1:0]    o_req_ack;
  logic [NR-1:0]    o_rsp_valid;
  logic [DW-1:0]    o_rsp_data;
  logic             o_rsp_err;
  logic             o_busy;

  spi_master_arbiter_if #(.DATA_SIZE(DW)) spi_if ();

  spi_master_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DW), .TIMEOUT(TO)) dut (
    .i_sys_clk  (clk),
    .i_sys_rst  (rst_n),
    .i_req      (i_req),
    .i_req_data (i_req_data),
    .i_req_addr (i_req_addr),
    .i_req_mode (i_req_mode),
    .o_req_ack  (o_req_ack),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_data (o_rsp_data),
    .o_rsp_err  (o_rsp_err),
    .o_busy     (o_busy),
    .spi        (spi_if)
  );

  xfer_t txq[$];
  xfer_t rspq[$];
  xfer_t mdlq[$];
  int n_vec = 0;
  int n_mis = 0;
  int n_rsp = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_rst_outs();
    chk("rst_ack",   32'(o_req_ack), 32'h0);
    chk("rst_rspv",  32'(o_rsp_valid), 32'h0);
    chk("rst_rspd",  32'(o_rsp_data), 32'h0);
    chk("rst_rspe",  32'(o_rsp_err), 32'h0);
    chk("rst_busy",  32'(o_busy), 32'h0);
    chk("rst_csn",   32'(spi_if.o_spi_csn), 32'h1);
    chk("rst_sdata", 32'(spi_if.o_spi_data), 32'h0);
    chk("rst_wr",    32'(spi_if.o_spi_wr), 32'h0);
    chk("rst_rd",    32'(spi_if.o_spi_rd), 32'h0);
    chk("rst_start", 32'(spi_if.o_spi_start), 32'h0);
    chk("rst_addr",  32'(spi_if.o_spi_addr), 32'h0);
    chk("rst_mode",  32'({spi_if.o_spi_cpol, spi_if.o_spi_cpha, spi_if.o_spi_lsb_first}), 32'h0);
  endtask

  task automatic push_x(input xfer_t x);
    txq.push_back(x);
    rspq.push_back(x);
    mdlq.push_back(x);
  endtask

  task automatic drive_slice(input xfer_t x);
    i_req_data[x.idx*DW +: DW] = x.tx;
    i_req_addr[x.idx*2 +: 2]   = x.addr;
    i_req_mode[x.idx*3 +: 3]   = x.mode;
  endtask

  task automatic wait_rsp(input int base, input int n);
    int t;
    t = 0;
    while ((n_rsp < base + n) && (t < 20 * (TO + 20))) begin
      @(posedge clk); #2;
      t++;
    end
    chk("rsp_count", 32'(n_rsp - base), 32'(n));
    @(posedge clk); #2;
  endtask

  task automatic do_req(input xfer_t x);
    int s;
    s = n_rsp;
    push_x(x);
    drive_slice(x);
    i_req[x.idx] = 1'b1;
    @(posedge clk); #2;
    chk("ack_latency", 32'(o_req_ack), 32'(1) << x.idx);
    i_req[x.idx] = 1'b0;
    wait_rsp(s, 1);
  endtask

  function automatic xfer_t mk(input int idx, input logic [15:0] tx, input logic [1:0] addr,
                               input logic [2:0] mode, input int delay, input logic [15:0] rx,
                               input bit err_pulse, input bit no_rx);
    xfer_t x;
    x.idx = idx; x.tx = tx; x.addr = addr; x.mode = mode; x.delay = delay;
    x.rx = rx; x.err_pulse = err_pulse; x.no_rx = no_rx;
    return x;
  endfunction

  // spi_master model: rx_ready rises in WAIT_RX cycle 'delay' after the start strobe
  initial begin : spi_model
    xfer_t m;
    int k;
    bit act;
    act = 1'b0;
    k = 0;
    spi_if.i_spi_rx_ready = 1'b0;
    spi_if.i_spi_rx_error = 1'b0;
    spi_if.i_spi_data     = 16'hDEAD;
    forever begin
      @(posedge clk); #1;
      spi_if.i_spi_rx_error = 1'b0;
      if (!rst_n) begin
        act = 1'b0;
        spi_if.i_spi_rx_ready = 1'b0;
      end else if (spi_if.o_spi_wr) begin
        if (mdlq.size() > 0) begin
          m = mdlq.pop_front();
          act = 1'b1;
          k = 0;
        end
      end else if (act) begin
        k++;
        if (m.err_pulse && k == 2) spi_if.i_spi_rx_error = 1'b1;
        if (!m.no_rx && k == 2 + m.delay) begin
          spi_if.i_spi_rx_ready = 1'b1;
          spi_if.i_spi_data     = m.rx;
        end
        if (spi_if.o_spi_rd) begin
          spi_if.i_spi_rx_ready = 1'b0;
          act = 1'b0;
        end
        if (o_rsp_valid != '0) act = 1'b0;
      end
    end
  end

  initial begin : monitor
    xfer_t a;
    xfer_t r;
    int ack_cyc;
    int c_wr;
    int c_start;
    int c_rd;
    ack_cyc = 0; c_wr = 0; c_start = 0; c_rd = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst_n) begin
        if (o_req_ack != '0) begin
          if (txq.size() == 0) begin
            chk("ack_unexpected", 32'(o_req_ack), 32'h0);
          end else begin
            a = txq.pop_front();
            chk("ack_grant", 32'(o_req_ack), 32'(1) << a.idx);
            chk("load_txword", 32'(spi_if.o_spi_data), 32'(a.tx));
            chk("load_addr", 32'(spi_if.o_spi_addr), 32'(a.addr));
            chk("load_mode", 32'({spi_if.o_spi_cpol, spi_if.o_spi_cpha, spi_if.o_spi_lsb_first}), 32'(a.mode));
            chk("load_csn", 32'(spi_if.o_spi_csn), 32'h0);
            chk("load_busy", 32'(o_busy), 32'h1);
          end
          ack_cyc = cyc; c_wr = 0; c_start = 0; c_rd = 0;
        end
        if (spi_if.o_spi_wr) c_wr++;
        if (spi_if.o_spi_start) c_start++;
        if (spi_if.o_spi_rd) c_rd++;
        if (o_rsp_valid != '0) begin
          n_rsp++;
          if (rspq.size() == 0) begin
            chk("rsp_unexpected", 32'(o_rsp_valid), 32'h0);
          end else begin
            r = rspq.pop_front();
            chk("rsp_valid", 32'(o_rsp_valid), 32'(1) << r.idx);
            chk("rsp_data", 32'(o_rsp_data), r.no_rx ? 32'h0 : 32'(r.rx));
            chk("rsp_err", 32'(o_rsp_err), 32'(r.no_rx | r.err_pulse));
            chk("rsp_latency", 32'(cyc - ack_cyc), r.no_rx ? 32'(TO + 3) : 32'(5 + r.delay));
            chk("wr_pulses", 32'(c_wr), 32'h1);
            chk("start_pulses", 32'(c_start), 32'h1);
            chk("rd_pulses", 32'(c_rd), r.no_rx ? 32'h0 : 32'h1);
            chk("resp_csn", 32'(spi_if.o_spi_csn), 32'h1);
            chk("resp_addr_hold", 32'(spi_if.o_spi_addr), 32'(r.addr));
          end
        end
      end
    end
  end

  initial begin : stim
    xfer_t x;
    int s;
    int na;
    int t;
    rst_n      = 1'b0;
    i_req      = '0;
    i_req_data = '0;
    i_req_addr = '0;
    i_req_mode = '0;
    spi_if.i_spi_tx_ready = 1'b1;
    spi_if.i_spi_tx_error = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_rst_outs();
    rst_n = 1'b1;
    @(posedge clk); #2;

    // single request, then timeout (req 2) and master error (req 3)
    do_req(mk(0, 16'hA5C3, 2'd2, 3'b010, 3, 16'h1234, 1'b0, 1'b0));
    do_req(mk(2, 16'h0F0F, 2'd1, 3'b100, 0, 16'hFFFF, 1'b0, 1'b1));
    do_req(mk(3, 16'h5A5A, 2'd3, 3'b111, 3, 16'hBEEF, 1'b1, 1'b0));

    // pointer now 3: all four held gives 0,1,2,3,0,1,2,3
    s = n_rsp;
    for (int k = 0; k < 8; k++) begin
      x = mk(k % NR, 16'h1100 + 16'(k % NR), 2'(k % NR), 3'(k % NR), 1 + (k % 3), 16'hC000 + 16'(k), 1'b0, 1'b0);
      push_x(x);
      drive_slice(x);
    end
    i_req = '1;
    na = 0; t = 0;
    while (na < 8 && t < 400) begin
      @(posedge clk); #2;
      t++;
      if (o_req_ack != '0) begin
        na++;
        if (na == 8) i_req = '0;
      end
    end
    i_req = '0;
    chk("rr_acks", 32'(na), 32'd8);
    wait_rsp(s, 8);

    // backpressure
    s = n_rsp;
    x = mk(1, 16'h3C3C, 2'd0, 3'b001, 2, 16'h7E57, 1'b0, 1'b0);
    push_x(x);
    drive_slice(x);
    spi_if.i_spi_tx_ready = 1'b0;
    i_req = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #2;
      chk("bp_noack", 32'(o_req_ack), 32'h0);
      chk("bp_busy", 32'(o_busy), 32'h0);
    end
    spi_if.i_spi_tx_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_ack", 32'(o_req_ack), 32'h2);
    i_req = '0;
    wait_rsp(s, 1);

    // reset in WAIT_RX while requester 2 is active
    x = mk(2, 16'h9999, 2'd2, 3'b011, 20, 16'h4444, 1'b0, 1'b0);
    push_x(x);
    drive_slice(x);
    i_req = 4'b0100;
    @(posedge clk); #2;
    chk("mid_ack", 32'(o_req_ack), 32'h4);
    i_req = '0;
    repeat (6) begin
      @(posedge clk); #2;
    end
    chk("mid_busy", 32'(o_busy), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk_rst_outs();
    txq.delete();
    rspq.delete();
    mdlq.delete();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      chk("rst_no_rsp", 32'(o_rsp_valid), 32'h0);
    end
    rst_n = 1'b1;

    // requester 0 must win over 3 after reset
    s = n_rsp;
    x = mk(0, 16'h0001, 2'd1, 3'b000, 1, 16'hAAAA, 1'b0, 1'b0);
    push_x(x);
    drive_slice(x);
    x = mk(3, 16'h0003, 2'd3, 3'b110, 2, 16'h5555, 1'b0, 1'b0);
    push_x(x);
    drive_slice(x);
    i_req = 4'b1001;
    na = 0; t = 0;
    while (na < 2 && t < 100) begin
      @(posedge clk); #2;
      t++;
      if (o_req_ack != '0) begin
        if (na == 0) chk("post_rst_first", 32'(o_req_ack), 32'h1);
        na++;
        if (na == 2) i_req = '0;
      end
    end
    i_req = '0;
    chk("post_rst_acks", 32'(na), 32'd2);
    wait_rsp(s, 2);

    for (int k = 0; k < 6; k++) begin
      do_req(mk($urandom_range(0, NR - 1), 16'($urandom), 2'($urandom), 3'($urandom),
                $urandom_range(1, 6), 16'($urandom), 1'b0, 1'b0));
    end

    chk("queues_drained", 32'(txq.size() + rspq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d responses", n_rsp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
Round-robin scheduler that shares one spi_master instance (16-bit word, host-side register interface) between NUM_REQ requesters. Each request is one full-duplex word to a chosen slave, with per-request CPOL/CPHA/LSB-first mode. The arbiter sequences the master's write/start/read strobes, captures the received word, and returns it to the granted requester. An RX timeout and error reporting are included. It sits between the board-level control logic and the SPI master.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_SIZE, 16, SPI word width; must match the spi_master DATA_SIZE
TIMEOUT, 4095, max cycles in WAIT_RX before abort; counter width clog2(TIMEOUT+1)

Ports:
i_sys_clk  in  1  system clock
i_sys_rst  in  1  asynchronous reset, active-low
i_req  in  NUM_REQ  per-requester request level
i_req_data  in  NUM_REQ*DATA_SIZE  TX word; requester k occupies slice k
i_req_addr  in  NUM_REQ*2  slave address; slice k
i_req_mode  in  NUM_REQ*3  {cpol,cpha,lsb_first}; slice k
o_req_ack  out  NUM_REQ  one-cycle accept pulse, one-hot
o_rsp_valid  out  NUM_REQ  one-cycle response pulse, one-hot
o_rsp_data  out  DATA_SIZE  received word, valid with o_rsp_valid
o_rsp_err  out  1  error flag, valid with o_rsp_valid
o_busy  out  1  high whenever state != IDLE
o_spi_csn  out  1  master register chip select (active-low)
o_spi_data  out  DATA_SIZE  word to master
o_spi_wr  out  1  master write strobe
o_spi_rd  out  1  master read strobe
o_spi_start  out  1  master start strobe
o_spi_addr  out  2  slave address to master
o_spi_cpol, o_spi_cpha, o_spi_lsb_first  out  1 each  mode to master
i_spi_data  in  DATA_SIZE  master read data
i_spi_tx_ready  in  1  master can accept a TX word
i_spi_rx_ready  in  1  master holds an RX word
i_spi_tx_error, i_spi_rx_error  in  1 each  master error flags

Behaviour:
- Reset (i_sys_rst=0, async): state IDLE; all strobes, o_req_ack, o_rsp_valid, o_rsp_err, o_busy = 0; o_spi_csn=1; o_spi_data, o_rsp_data, addr and mode outputs = 0; RR pointer = NUM_REQ-1, so requester 0 wins first. Reset mid-transfer aborts with no response pulse.
- States: IDLE -> LOAD -> START -> WAIT_RX -> READ -> CAPTURE -> RESP -> IDLE.
- IDLE: when any i_req is set and i_spi_tx_ready=1, grant g = the first asserted index after the pointer, searching upward with wrap. On that edge, register slice g of data, addr and mode; set pointer = g; go to LOAD. If i_spi_tx_ready=0, stay in IDLE and do not grant.
- LOAD (1 cycle): o_req_ack[g]=1, o_spi_csn=0, o_spi_wr=1.
- START (1 cycle): o_spi_start=1.
- WAIT_RX: o_spi_csn=0; timeout counter increments each cycle. On i_spi_rx_ready=1 go to READ. If the counter reaches TIMEOUT first, set err and go to RESP with o_rsp_data=0.
- READ (1 cycle): o_spi_rd=1, o_spi_csn=0.
- CAPTURE (1 cycle): latch i_spi_data into o_rsp_data.
- RESP (1 cycle): o_rsp_valid[g]=1; o_rsp_err = err OR any tx/rx error sampled from LOAD through CAPTURE; o_spi_csn=1.
- Addr and mode outputs hold their values from LOAD through RESP and keep the last values while IDLE.
- Latency: request seen in IDLE to ack is 1 cycle. Ack to o_rsp_valid is 5 + N cycles, where N is the number of WAIT_RX cycles before rx_ready (N ≥ 1).
- Requester protocol: hold i_req, data, addr and mode stable until ack. i_req still high on the cycle after ack counts as a new request. Dropping i_req before ack withdraws the request with no side effects.
- Fairness: with all requests asserted continuously, grants cycle 0,1,2,3,0,... A requester waits at most NUM_REQ-1 transfers.
- i_req activity outside IDLE is ignored.

Test Plan:
- Single request: i_req=0001, data 0xA5C3, addr 2, mode 3'b010, tx_ready=1, rx_ready 3 cycles after start, i_spi_data=0x1234. Expect ack[0] 1 cycle after req; one wr, one start, one rd pulse; o_spi_addr=2, cpha=1; rsp_valid[0] with 0x1234 and err=0, 8 cycles after ack.
- Round-robin: i_req=1111 held for 8 transfers. Expect grant order 0,1,2,3,0,1,2,3 and exactly one ack per transfer.
- Timeout: i_req=0100, rx_ready never asserted. Expect rsp_valid[2] with data 0x0000 and err=1, TIMEOUT+3 cycles after ack; state returns to IDLE.
- Master error: i_spi_rx_error pulsed during WAIT_RX. Expect rsp_err=1 alongside the captured data.
- Backpressure: tx_ready=0 for 10 cycles with i_req=0010. Expect no ack and o_busy=0; ack 1 cycle after tx_ready rises.
- Reset mid-transfer: drop i_sys_rst in WAIT_RX. Expect all outputs at reset values immediately and no rsp_valid. After release, requester 0 has priority.
